// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback path: scheduler states,
// default widths and the writeback-select mux encoding.
package wb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RAW_DEF  = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HOLD  = 2'b01,
    FORCE = 2'b10
  } wb_state_t;

  // Writeback-select encoding driving the pipeline-side mux ahead of this block.
  typedef enum logic [1:0] {
    WB_SEL_PC4  = 2'b00,
    WB_SEL_C    = 2'b01,
    WB_SEL_DRAM = 2'b10,
    WB_SEL_IMM  = 2'b11
  } wb_sel_t;

endpackage

// File: rtl/wb_hold_buf.sv
// Single-entry holding register for an MDU result that lost the write port,
// with a destination compare used to squash it on a younger pipeline write.
module wb_hold_buf #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [RAW-1:0]  load_rd,
  input  logic [XLEN-1:0] load_data,
  input  logic [RAW-1:0]  cmp_rd,
  output logic [RAW-1:0]  buf_rd,
  output logic [XLEN-1:0] buf_data,
  output logic            match
);

  // NOTE: sequential state is written with <= only, so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_rd <= '0;
    end else if (load) begin
      buf_rd <= load_rd;
    end else if (clear) begin
      buf_rd <= '0;
    end
  end

  // NOTE: the data word carries no reset; validity lives in the owner's FSM,
  // so resetting the payload would only cost a wider reset tree.
  always_ff @(posedge clk) begin
    if (load) begin
      buf_data <= load_data;
    end
  end

  assign match = (buf_rd == cmp_rd);

endmodule

// File: rtl/wb_port_arbiter.sv
// Schedules the single register-file write port between in-order pipeline
// writeback and out-of-band MDU results, buffering one MDU result with bounded wait.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int RAW      = RAW_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_valid,
  input  logic [RAW-1:0]  pipe_rd,
  input  logic [XLEN-1:0] pipe_wdata,
  output logic            pipe_stall,
  input  logic            mdu_valid,
  input  logic [RAW-1:0]  mdu_rd,
  input  logic [XLEN-1:0] mdu_wdata,
  output logic            mdu_ready,
  output logic            rf_we,
  output logic [RAW-1:0]  rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            pend_valid,
  output logic [RAW-1:0]  pend_rd
);

  wb_state_t       state;
  logic [3:0]      wait_cnt;

  logic            pipe_live;
  logic            mdu_live;
  logic            wr_en;
  logic [RAW-1:0]  wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            buf_load;
  logic            buf_clear;
  logic [RAW-1:0]  buf_rd;
  logic [XLEN-1:0] buf_data;
  logic            buf_match;

  wb_hold_buf #(.XLEN(XLEN), .RAW(RAW)) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_rd   (mdu_rd),
    .load_data (mdu_wdata),
    .cmp_rd    (pipe_rd),
    .buf_rd    (buf_rd),
    .buf_data  (buf_data),
    .match     (buf_match)
  );

  assign mdu_ready  = (state == EMPTY);
  assign pipe_stall = (state == FORCE);
  assign pend_valid = (state != EMPTY);
  assign pend_rd    = buf_rd;

  // Writes to x0 are consumed but never reach the register file.
  assign pipe_live = pipe_valid && (pipe_rd != '0);
  assign mdu_live  = mdu_valid && mdu_ready && (mdu_rd != '0);

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = pipe_rd;
    wr_data   = pipe_wdata;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    unique case (state)
      EMPTY: begin
        if (pipe_live) begin
          wr_en    = 1'b1;
          buf_load = mdu_live;
        end else if (mdu_live) begin
          wr_en   = 1'b1;
          wr_addr = mdu_rd;
          wr_data = mdu_wdata;
        end
      end
      HOLD: begin
        if (pipe_live) begin
          wr_en     = 1'b1;
          buf_clear = buf_match;
        end else begin
          wr_en     = 1'b1;
          wr_addr   = buf_rd;
          wr_data   = buf_data;
          buf_clear = 1'b1;
        end
      end
      FORCE: begin
        wr_en     = 1'b1;
        wr_addr   = buf_rd;
        wr_data   = buf_data;
        buf_clear = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      wait_cnt <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_en;
      if (wr_en) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
      unique case (state)
        EMPTY: begin
          if (pipe_live && mdu_live) begin
            state    <= HOLD;
            wait_cnt <= '0;
          end
        end
        HOLD: begin
          if (!pipe_live || buf_match) begin
            // Buffer drained, or squashed by a younger write to the same rd.
            state    <= EMPTY;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
            if (wait_cnt == 4'(MAX_WAIT - 1)) begin
              state <= FORCE;
            end
          end
        end
        FORCE: begin
          state    <= EMPTY;
          wait_cnt <= '0;
        end
        default: begin
          state    <= EMPTY;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a behavioural pending-result model.
module tb_wb_port_arbiter;

  localparam int XLEN     = 32;
  localparam int RAW      = 5;
  localparam int MAX_WAIT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            pipe_valid;
  logic [RAW-1:0]  pipe_rd;
  logic [XLEN-1:0] pipe_wdata;
  logic            pipe_stall;
  logic            mdu_valid;
  logic [RAW-1:0]  mdu_rd;
  logic [XLEN-1:0] mdu_wdata;
  logic            mdu_ready;
  logic            rf_we;
  logic [RAW-1:0]  rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            pend_valid;
  logic [RAW-1:0]  pend_rd;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: an optional pending MDU result and how many times it has lost the port.
  logic            m_pend;
  logic [RAW-1:0]  m_rd;
  logic [XLEN-1:0] m_data;
  int              m_losses;
  logic            exp_we;
  logic [RAW-1:0]  exp_waddr;
  logic [XLEN-1:0] exp_wdata;

  wb_port_arbiter #(.XLEN(XLEN), .RAW(RAW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_wdata (pipe_wdata),
    .pipe_stall (pipe_stall),
    .mdu_valid  (mdu_valid),
    .mdu_rd     (mdu_rd),
    .mdu_wdata  (mdu_wdata),
    .mdu_ready  (mdu_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pend_valid (pend_valid),
    .pend_rd    (pend_rd)
  );

  always #5 clk = ~clk;

  function automatic logic model_stall();
    return m_pend && (m_losses == MAX_WAIT);
  endfunction

  task automatic model_reset();
    m_pend    = 1'b0;
    m_rd      = '0;
    m_data    = '0;
    m_losses  = 0;
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  // Called at a falling edge: drive one cycle of requests, compare the DUT
  // against the model, advance the model, and move to the next falling edge.
  task automatic step(input logic pv, input logic [RAW-1:0] prd, input logic [XLEN-1:0] pd,
                      input logic mv, input logic [RAW-1:0] mrd, input logic [XLEN-1:0] md);
    logic            w;
    logic [RAW-1:0]  wa;
    logic [XLEN-1:0] wd;
    logic            p_live;
    logic            m_live;
    pipe_valid = pv; pipe_rd = prd; pipe_wdata = pd;
    mdu_valid  = mv; mdu_rd  = mrd; mdu_wdata  = md;

    n_checks++;
    if (mdu_ready !== !m_pend) begin
      n_fail++; $display("FAIL mdu_ready: got %b expected %b", mdu_ready, !m_pend);
    end
    n_checks++;
    if (pipe_stall !== model_stall()) begin
      n_fail++; $display("FAIL pipe_stall: got %b expected %b", pipe_stall, model_stall());
    end
    n_checks++;
    if (pend_valid !== m_pend) begin
      n_fail++; $display("FAIL pend_valid: got %b expected %b", pend_valid, m_pend);
    end
    if (m_pend) begin
      n_checks++;
      if (pend_rd !== m_rd) begin
        n_fail++; $display("FAIL pend_rd: got %0d expected %0d", pend_rd, m_rd);
      end
    end
    n_checks++;
    if (rf_we !== exp_we) begin
      n_fail++; $display("FAIL rf_we: got %b expected %b", rf_we, exp_we);
    end
    n_checks++;
    if (rf_waddr !== exp_waddr || rf_wdata !== exp_wdata) begin
      n_fail++;
      $display("FAIL rf_write: got x%0d=%h expected x%0d=%h", rf_waddr, rf_wdata, exp_waddr, exp_wdata);
    end

    p_live = pv && (prd != '0);
    m_live = mv && !m_pend && (mrd != '0);
    w = 1'b0; wa = '0; wd = '0;
    if (model_stall()) begin
      w = 1'b1; wa = m_rd; wd = m_data; m_pend = 1'b0;
    end else if (m_pend) begin
      if (p_live) begin
        w = 1'b1; wa = prd; wd = pd;
        if (prd == m_rd) m_pend = 1'b0;
        else m_losses++;
      end else begin
        w = 1'b1; wa = m_rd; wd = m_data; m_pend = 1'b0;
      end
    end else if (p_live) begin
      w = 1'b1; wa = prd; wd = pd;
      if (m_live) begin
        m_pend = 1'b1; m_rd = mrd; m_data = md; m_losses = 0;
      end
    end else if (m_live) begin
      w = 1'b1; wa = mrd; wd = md;
    end
    exp_we = w;
    if (w) begin
      exp_waddr = wa;
      exp_wdata = wd;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic apply_reset();
    pipe_valid = 1'b0; pipe_rd = '0; pipe_wdata = '0;
    mdu_valid  = 1'b0; mdu_rd  = '0; mdu_wdata  = '0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      n_fail++; $display("FAIL reset_rf: got we=%b x%0d=%h expected we=0 x0=0", rf_we, rf_waddr, rf_wdata);
    end
    n_checks++;
    if (mdu_ready !== 1'b1 || pipe_stall !== 1'b0 || pend_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got ready=%b stall=%b pend=%b expected 1 0 0",
                         mdu_ready, pipe_stall, pend_valid);
    end
    idle();
  endtask

  task automatic test_bypass();
    step(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_write: got we=%b x%0d=%h expected we=1 x5=deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    n_checks++;
    if (mdu_ready !== 1'b1 || pend_valid !== 1'b0) begin
      n_fail++; $display("FAIL bypass_state: got ready=%b pend=%b expected 1 0", mdu_ready, pend_valid);
    end
    idle();
  endtask

  task automatic test_concurrent();
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    n_checks++;
    if (rf_waddr !== 5'd3 || rf_wdata !== 32'h11 || pend_valid !== 1'b1 || pend_rd !== 5'd7) begin
      n_fail++; $display("FAIL concurrent_pipe: got x%0d=%h pend=%b rd=%0d expected x3=11 pend=1 rd=7",
                         rf_waddr, rf_wdata, pend_valid, pend_rd);
    end
    idle();
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h22 || pend_valid !== 1'b0) begin
      n_fail++; $display("FAIL concurrent_drain: got we=%b x%0d=%h pend=%b expected we=1 x7=22 pend=0",
                         rf_we, rf_waddr, rf_wdata, pend_valid);
    end
    idle();
  endtask

  task automatic test_force();
    step(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h999);
    for (int i = 0; i < MAX_WAIT; i++) begin
      step(1'b1, 5'(10 + i), 32'h200 + 32'(i), 1'b0, '0, '0);
      n_checks++;
      if (rf_waddr !== 5'(10 + i) || pipe_stall !== (i == MAX_WAIT - 1)) begin
        n_fail++; $display("FAIL force_hold%0d: got x%0d stall=%b expected x%0d stall=%b",
                           i, rf_waddr, pipe_stall, 10 + i, i == MAX_WAIT - 1);
      end
    end
    step(1'b1, 5'd20, 32'h2020, 1'b0, '0, '0);
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h999 || pipe_stall !== 1'b0) begin
      n_fail++; $display("FAIL force_drain: got we=%b x%0d=%h stall=%b expected we=1 x9=999 stall=0",
                         rf_we, rf_waddr, rf_wdata, pipe_stall);
    end
    step(1'b1, 5'd20, 32'h2020, 1'b0, '0, '0);
    n_checks++;
    if (rf_waddr !== 5'd20 || rf_wdata !== 32'h2020) begin
      n_fail++; $display("FAIL force_replay: got x%0d=%h expected x20=2020", rf_waddr, rf_wdata);
    end
    idle();
  endtask

  task automatic test_waw();
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'hAA);
    step(1'b1, 5'd4, 32'hBB, 1'b0, '0, '0);
    n_checks++;
    if (rf_waddr !== 5'd4 || rf_wdata !== 32'hBB || pend_valid !== 1'b0) begin
      n_fail++; $display("FAIL waw_write: got x%0d=%h pend=%b expected x4=bb pend=0", rf_waddr, rf_wdata, pend_valid);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      n_checks++;
      if (rf_we !== 1'b0) begin
        n_fail++; $display("FAIL waw_no_stale%0d: got we=%b x%0d=%h expected we=0", i, rf_we, rf_waddr, rf_wdata);
      end
    end
  endtask

  task automatic test_rd_zero();
    step(1'b1, 5'd0, 32'h55, 1'b0, '0, '0);
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'h66);
    n_checks++;
    if (rf_we !== 1'b0 || mdu_ready !== 1'b1 || pend_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd0_mdu: got we=%b ready=%b pend=%b expected 0 1 0", rf_we, mdu_ready, pend_valid);
    end
    step(1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h88);
    n_checks++;
    if (rf_we !== 1'b0 || mdu_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd0_both: got we=%b ready=%b expected 0 1", rf_we, mdu_ready);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    step(1'b1, 5'd2, 32'h2, 1'b1, 5'd12, 32'hC0C0);
    n_checks++;
    if (pend_valid !== 1'b1 || pend_rd !== 5'd12) begin
      n_fail++; $display("FAIL midrst_setup: got pend=%b rd=%0d expected 1 12", pend_valid, pend_rd);
    end
    apply_reset();
    n_checks++;
    if (rf_we !== 1'b0 || pend_valid !== 1'b0 || mdu_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_after: got we=%b pend=%b ready=%b expected 0 0 1", rf_we, pend_valid, mdu_ready);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      n_checks++;
      if (rf_we === 1'b1 && rf_waddr === 5'd12) begin
        n_fail++; $display("FAIL midrst_no_x12: got write x12=%h expected none", rf_wdata);
      end
    end
  endtask

  task automatic test_random();
    logic            pv = 1'b0, mv = 1'b0, hold_pipe = 1'b0, hold_mdu = 1'b0;
    logic [RAW-1:0]  prd = '0, mrd = '0;
    logic [XLEN-1:0] pd = '0, md = '0;
    logic            stall_now, ready_now;
    for (int c = 0; c < 3000; c++) begin
      if (!hold_pipe) begin
        pv  = ($urandom_range(0, 9) < 7);
        prd = RAW'($urandom_range(0, 7));
        pd  = $urandom;
      end
      if (!hold_mdu) begin
        mv  = ($urandom_range(0, 9) < 4);
        mrd = RAW'($urandom_range(0, 7));
        md  = $urandom;
      end
      stall_now = model_stall();
      ready_now = !m_pend;
      step(pv, prd, pd, mv, mrd, md);
      hold_pipe = pv && stall_now;
      hold_mdu  = mv && !ready_now;
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    pipe_valid = 1'b0; pipe_rd = '0; pipe_wdata = '0;
    mdu_valid  = 1'b0; mdu_rd  = '0; mdu_wdata  = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_bypass();
    test_concurrent();
    test_force();
    test_waw();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
